// File: rtl/wb_port_arb.sv
// wb_port_arb: two-requester writeback arbiter feeding one registered register-file write port; define WB_PORT_ARB_RR_EN for round-robin contention, otherwise s0 has fixed priority
module wb_port_arb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [AW-1:0]   s0_addr,
  input  logic [XLEN-1:0] s0_data,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [AW-1:0]   s1_addr,
  input  logic [XLEN-1:0] s1_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [AW-1:0]   m_addr,
  output logic [XLEN-1:0] m_data,
  output logic            grant_last
);
  logic            cke, sel1, xfer;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            m_valid_d, m_valid_q;
  logic [AW-1:0]   m_addr_d, m_addr_q;
  logic [XLEN-1:0] m_data_d, m_data_q;
  logic            grant_last_d, grant_last_q;
  assign m_valid    = m_valid_q;
  assign m_addr     = m_addr_q;
  assign m_data     = m_data_q;
  assign grant_last = grant_last_q;
  // select a requester, grant it only when the output register can load, and compute next register state
  always_comb begin
    cke = ~m_valid_q | m_ready;
`ifdef WB_PORT_ARB_RR_EN
    sel1 = s1_valid & (~s0_valid | ~grant_last_q);
`else
    sel1 = s1_valid & ~s0_valid;
`endif
    s0_ready     = rst_n & cke & s0_valid & ~sel1;
    s1_ready     = rst_n & cke & sel1;
    xfer         = s0_ready | s1_ready;
    sel_addr     = sel1 ? s1_addr : s0_addr;
    sel_data     = sel1 ? s1_data : s0_data;
    m_valid_d    = cke ? (xfer & (sel_addr != '0)) : m_valid_q;
    m_addr_d     = xfer ? sel_addr : m_addr_q;
    m_data_d     = xfer ? sel_data : m_data_q;
    grant_last_d = xfer ? sel1 : grant_last_q;
  end
  // output register; x0 writes are consumed but never raise m_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q    <= 1'b0;
      m_addr_q     <= '0;
      m_data_q     <= '0;
      grant_last_q <= 1'b1;
    end else begin
      m_valid_q    <= m_valid_d;
      m_addr_q     <= m_addr_d;
      m_data_q     <= m_data_d;
      grant_last_q <= grant_last_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arb.sv
// tb_wb_port_arb: scoreboard bench for wb_port_arb
module tb_wb_port_arb;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  logic            clk, rst_n;
  logic            s0_valid, s0_ready, s1_valid, s1_ready;
  logic [AW-1:0]   s0_addr, s1_addr, m_addr;
  logic [XLEN-1:0] s0_data, s1_data, m_data;
  logic            m_valid, m_ready, grant_last;
  int total = 0, bad = 0;
  logic mv, gl;
  logic [AW+XLEN-1:0] q[$];
  logic [AW+XLEN-1:0] sb_e;
  logic [AW-1:0]   ma;
  logic [XLEN-1:0] md;
  logic a0, a1, exp0;

  wb_port_arb #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .grant_last(grant_last)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic e_cke();
    return !mv || m_ready;
  endfunction

  function automatic logic e_sel1();
`ifdef WB_PORT_ARB_RR_EN
    return s1_valid && (!s0_valid || !gl);
`else
    return s1_valid && !s0_valid;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 1'b0;
      gl <= 1'b1;
      q.delete();
    end else if (e_cke() && (s0_valid || s1_valid)) begin
      gl <= e_sel1();
      mv <= e_sel1() ? (s1_addr != 0) : (s0_addr != 0);
      if (e_sel1() ? (s1_addr != 0) : (s0_addr != 0))
        q.push_back(e_sel1() ? {s1_addr, s1_data} : {s0_addr, s0_data});
    end else if (e_cke()) begin
      mv <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("s0_ready", s0_ready, e_cke() && s0_valid && !e_sel1());
      chk("s1_ready", s1_ready, e_cke() && e_sel1());
      chk("m_valid", m_valid, mv);
      chk("grant_last", grant_last, gl);
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("sb_pending", q.size(), 1);
        else begin
          sb_e = q.pop_front();
          chk("sb_addr", m_addr, sb_e[AW+XLEN-1:XLEN]);
          chk("sb_data", m_data, sb_e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 0; m_ready = 0;
    s0_valid = 1; s0_addr = 7; s0_data = 32'h1234_5678;
    s1_valid = 0; s1_addr = 0; s1_data = 0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_grant_last", grant_last, 1);
    chk("rst_s0_ready", s0_ready, 0);
    step();
    s0_valid = 0; rst_n = 1;
    step();
    s0_valid = 1; s0_addr = 3; s0_data = 32'hDEAD_BEEF; m_ready = 1;
    @(negedge clk);
    chk("single_s0_ready", s0_ready, 1);
    step();
    s0_valid = 0;
    @(negedge clk);
    chk("single_m_valid", m_valid, 1);
    chk("single_m_addr", m_addr, 3);
    chk("single_m_data", m_data, 32'hDEAD_BEEF);
    step();
    s1_valid = 1; s1_addr = 6; s1_data = 32'hA000_0000;
    @(negedge clk);
    chk("single_s1_ready", s1_ready, 1);
    step();
    s1_data = 32'hA000_0001;
    s0_valid = 1; s0_addr = 5; s0_data = 32'h5000_0000;
    for (int i = 0; i < 4; i++) begin
`ifdef WB_PORT_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1;
`endif
      @(negedge clk);
      chk("cont_s0_ready", s0_ready, exp0);
      chk("cont_s1_ready", s1_ready, !exp0);
      step();
      if (exp0) s0_data = s0_data + 1;
      else s1_data = s1_data + 1;
    end
    m_ready = 0;
    @(negedge clk);
    ma = m_addr; md = m_data;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_s0_ready", s0_ready, 0);
      chk("bp_s1_ready", s1_ready, 0);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_addr", m_addr, ma);
      chk("bp_m_data", m_data, md);
      step();
    end
    m_ready = 1;
    @(negedge clk);
    chk("bp_release_grant", s0_ready | s1_ready, 1);
    step();
    s0_valid = 0; s1_valid = 0;
    step();
    s1_valid = 1; s1_addr = 0; s1_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("x0_s1_ready", s1_ready, 1);
    step();
    s1_valid = 0;
    @(negedge clk);
    chk("x0_m_valid", m_valid, 0);
    chk("x0_grant_last", grant_last, 1);
    step();
    s0_valid = 1; s0_addr = 9; s0_data = 32'h0909_0909; m_ready = 0;
    @(negedge clk);
    chk("mid_s0_ready", s0_ready, 1);
    step();
    s0_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    step();
    rst_n = 1;
    s0_valid = 1; s0_addr = 12; s0_data = 32'hC0FF_EE00; m_ready = 1;
    @(negedge clk);
    chk("post_rst_s0_ready", s0_ready, 1);
    step();
    s0_valid = 0;
    @(negedge clk);
    chk("post_rst_m_valid", m_valid, 1);
    chk("post_rst_m_addr", m_addr, 12);
    chk("post_rst_m_data", m_data, 32'hC0FF_EE00);
    step();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a0 = s0_valid && s0_ready;
      a1 = s1_valid && s1_ready;
      step();
      if (!s0_valid || a0) begin
        s0_valid = 1'($urandom_range(0, 1));
        s0_addr = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
        s0_data = $urandom;
      end
      if (!s1_valid || a1) begin
        s1_valid = 1'($urandom_range(0, 1));
        s1_addr = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
        s1_data = $urandom;
      end
      m_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    a0 = s0_valid && s0_ready;
    a1 = s1_valid && s1_ready;
    step();
    if (a0) s0_valid = 0;
    if (a1) s1_valid = 0;
    m_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a0 = s0_valid && s0_ready;
      a1 = s1_valid && s1_ready;
      step();
      if (a0) s0_valid = 0;
      if (a1) s1_valid = 0;
    end
    @(negedge clk);
    chk("drain_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
